mem_port_arbiter: RTL and testbench

Arbiter for the shared data port of the unified instruction/data memory. It shares the single data port between two requesters: the pipeline's MEM stage (port 0, "cpu") and the program/data loader (port 1, "ld"). The data port consists of address, write data, write enable and read data. It grants at most one access per cycle, gives the CPU priority with a starvation bound for the loader, and supports a loader burst lock. The instruction-fetch port of the memory is not touched by this block.

---
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 93 +++++++++
 tb/tb_mem_port_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Shared memory data-port bundle: CPU and loader requesters plus the
// memory-side address/data/write-enable signals.
interface mem_port_arbiter_if #(
  parameter int WIDTH = 16
);
  logic             cpu_req;
  logic             cpu_we;
  logic [WIDTH-1:0] cpu_addr;
  logic [WIDTH-1:0] cpu_wdata;
  logic             cpu_gnt;
  logic             cpu_stall;
  logic             cpu_rvalid;

  logic             ld_req;
  logic             ld_we;
  logic             ld_lock;
  logic [WIDTH-1:0] ld_addr;
  logic [WIDTH-1:0] ld_wdata;
  logic             ld_gnt;
  logic             ld_rvalid;

  logic [WIDTH-1:0] rdata;
  logic             mem_we;
  logic [WIDTH-1:0] mem_a;
  logic [WIDTH-1:0] mem_wd;
  logic [WIDTH-1:0] mem_rd;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ld_req, ld_we, ld_lock, ld_addr, ld_wdata,
    input  mem_rd,
    output cpu_gnt, cpu_stall, cpu_rvalid,
    output ld_gnt, ld_rvalid,
    output rdata, mem_we, mem_a, mem_wd
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ld_req, ld_we, ld_lock, ld_addr, ld_wdata,
    output mem_rd,
    input  cpu_gnt, cpu_stall, cpu_rvalid,
    input  ld_gnt, ld_rvalid,
    input  rdata, mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Data-port arbiter between the MEM stage (cpu) and the loader (ld):
// CPU priority, bounded loader starvation, loader burst lock.
module mem_port_arbiter #(
  parameter int WIDTH   = 16,
  parameter int MAXWAIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam logic [3:0] MAXW = 4'(MAXWAIT);

  state_t     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic       cpu_rv_q, cpu_rv_d;
  logic       ld_rv_q, ld_rv_d;
  logic       cpu_gnt, ld_gnt;

  // Grant decision and next state; grants are forced low while in reset
  always_comb begin
    cpu_gnt = 1'b0;
    ld_gnt  = 1'b0;
    state_d = state_q;
    unique case (state_q)
      ARB: begin
        if (bus.ld_req && wait_q == MAXW) begin
          ld_gnt = 1'b1;
        end else if (bus.cpu_req) begin
          cpu_gnt = 1'b1;
        end else if (bus.ld_req) begin
          ld_gnt = 1'b1;
        end
        if (ld_gnt && bus.ld_lock) begin
          state_d = LOCK;
        end
      end
      LOCK: begin
        ld_gnt = bus.ld_req;
        if (!(bus.ld_req && bus.ld_lock)) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
    if (!rst) begin
      cpu_gnt = 1'b0;
      ld_gnt  = 1'b0;
    end
  end

  // Loader starvation counter and read-response tracking
  always_comb begin
    wait_d = 4'd0;
    if (bus.ld_req && !ld_gnt) begin
      wait_d = (wait_q == MAXW) ? MAXW : wait_q + 4'd1;
    end
    cpu_rv_d = cpu_gnt && !bus.cpu_we;
    ld_rv_d  = ld_gnt && !bus.ld_we;
  end

  // State, wait counter and rvalid registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ARB;
      wait_q   <= 4'd0;
      cpu_rv_q <= 1'b0;
      ld_rv_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      cpu_rv_q <= cpu_rv_d;
      ld_rv_q  <= ld_rv_d;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.ld_gnt     = ld_gnt;
  assign bus.cpu_stall  = rst && bus.cpu_req && !cpu_gnt;
  assign bus.cpu_rvalid = cpu_rv_q;
  assign bus.ld_rvalid  = ld_rv_q;
  assign bus.rdata      = bus.mem_rd;

  assign bus.mem_we = (cpu_gnt && bus.cpu_we) || (ld_gnt && bus.ld_we);
  assign bus.mem_a  = ld_gnt ? bus.ld_addr : bus.cpu_addr;
  assign bus.mem_wd = ld_gnt ? bus.ld_wdata : bus.cpu_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic
// against a behavioural model of the arbitration rules and memory.
module tb_mem_port_arbiter;
  localparam int W  = 16;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.WIDTH(W)) bus ();

  mem_port_arbiter #(.WIDTH(W), .MAXWAIT(MW)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  logic [W-1:0] mem [256];
  bit           filled;

  // memory model: synchronous write, registered read (old data)
  always @(posedge clk) begin
    if (!filled) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 + 16'(i);
      filled <= 1'b1;
    end else if (bus.mem_we) begin
      mem[bus.mem_a[7:0]] <= bus.mem_wd;
    end
    bus.mem_rd <= mem[bus.mem_a[7:0]];
  end

  task automatic drive(input bit cr, input bit cw,
                       input logic [W-1:0] ca, input logic [W-1:0] cd,
                       input bit lr, input bit lw, input bit ll,
                       input logic [W-1:0] la, input logic [W-1:0] lwd);
    bus.cpu_req   = cr;
    bus.cpu_we    = cw;
    bus.cpu_addr  = ca;
    bus.cpu_wdata = cd;
    bus.ld_req    = lr;
    bus.ld_we     = lw;
    bus.ld_lock   = ll;
    bus.ld_addr   = la;
    bus.ld_wdata  = lwd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 1, 8, 16'h55, 1, 1, 1, 3, 16'h66);
    @(negedge clk);
    vectors++;
    if (bus.cpu_gnt !== 1'b0 || bus.ld_gnt !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_gnt: got cpu=%b ld=%b want 0 0", bus.cpu_gnt, bus.ld_gnt);
    end
    vectors++;
    if (bus.mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_we: got %b want 0", bus.mem_we);
    end
    vectors++;
    if (bus.cpu_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_stall: got %b want 0", bus.cpu_stall);
    end
    vectors++;
    if (bus.cpu_rvalid !== 1'b0 || bus.ld_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_rvalid: got cpu=%b ld=%b want 0 0",
               bus.cpu_rvalid, bus.ld_rvalid);
    end
    tick();
    tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_cpu_rw();
    drive(1, 1, 8, 16'h25, 0, 0, 0, 0, 0);
    @(negedge clk);
    vectors++;
    if (bus.cpu_gnt !== 1'b1 || bus.cpu_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL cpu_wr_gnt: got gnt=%b stall=%b want 1 0", bus.cpu_gnt, bus.cpu_stall);
    end
    vectors++;
    if (bus.mem_we !== 1'b1 || bus.mem_a !== 16'd8 || bus.mem_wd !== 16'h25) begin
      miscompares++;
      $display("FAIL cpu_wr_bus: got we=%b a=%h wd=%h want 1 0008 0025",
               bus.mem_we, bus.mem_a, bus.mem_wd);
    end
    tick();
    drive(1, 0, 8, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    vectors++;
    if (bus.cpu_gnt !== 1'b1 || bus.cpu_stall !== 1'b0 || bus.cpu_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL cpu_rd_gnt: got gnt=%b stall=%b rv=%b want 1 0 0",
               bus.cpu_gnt, bus.cpu_stall, bus.cpu_rvalid);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    vectors++;
    if (bus.cpu_rvalid !== 1'b1 || bus.rdata !== 16'h25) begin
      miscompares++;
      $display("FAIL cpu_rd_data: got rv=%b rdata=%h want 1 0025", bus.cpu_rvalid, bus.rdata);
    end
    tick();
  endtask

  task automatic test_starvation();
    bit exp_ld;
    drive(1, 0, 8, 0, 1, 0, 0, 7, 0);
    for (int i = 0; i < 15; i++) begin
      exp_ld = (i % 5 == 4);
      @(negedge clk);
      vectors++;
      if (bus.ld_gnt !== exp_ld || bus.cpu_gnt !== !exp_ld || bus.cpu_stall !== exp_ld) begin
        miscompares++;
        $display("FAIL starve[%0d]: got ld=%b cpu=%b stall=%b want %b %b %b",
                 i, bus.ld_gnt, bus.cpu_gnt, bus.cpu_stall, exp_ld, !exp_ld, exp_ld);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_lock_burst();
    drive(1, 0, 5, 0, 1, 1, 1, 0, 16'h100);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.cpu_gnt !== 1'b1 || bus.ld_gnt !== 1'b0) begin
        miscompares++;
        $display("FAIL lock_prime[%0d]: got cpu=%b ld=%b want 1 0", i, bus.cpu_gnt, bus.ld_gnt);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 5, 0, 1, 1, 1, 16'(i), 16'h100 + 16'(i));
      @(negedge clk);
      vectors++;
      if (bus.ld_gnt !== 1'b1 || bus.cpu_stall !== 1'b1 || bus.cpu_gnt !== 1'b0) begin
        miscompares++;
        $display("FAIL lock_gnt[%0d]: got ld=%b stall=%b cpu=%b want 1 1 0",
                 i, bus.ld_gnt, bus.cpu_stall, bus.cpu_gnt);
      end
      vectors++;
      if (bus.mem_we !== 1'b1 || bus.mem_a !== 16'(i)) begin
        miscompares++;
        $display("FAIL lock_bus[%0d]: got we=%b a=%h want 1 %h", i, bus.mem_we, bus.mem_a, 16'(i));
      end
      tick();
    end
    drive(1, 0, 5, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    vectors++;
    if (bus.cpu_gnt !== 1'b0 || bus.cpu_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL lock_drop: got cpu=%b stall=%b want 0 1", bus.cpu_gnt, bus.cpu_stall);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (bus.cpu_gnt !== 1'b1 || bus.cpu_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL lock_exit: got cpu=%b stall=%b want 1 0", bus.cpu_gnt, bus.cpu_stall);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_rvalid_seq();
    drive(0, 0, 0, 0, 1, 0, 0, 7, 0);
    @(negedge clk);
    vectors++;
    if (bus.ld_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL rv_ld_gnt: got %b want 1", bus.ld_gnt);
    end
    tick();
    drive(1, 0, 8, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    vectors++;
    if (bus.ld_rvalid !== 1'b1 || bus.cpu_rvalid !== 1'b0 || bus.rdata !== 16'hA007) begin
      miscompares++;
      $display("FAIL rv_ld: got ld=%b cpu=%b rdata=%h want 1 0 a007",
               bus.ld_rvalid, bus.cpu_rvalid, bus.rdata);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    vectors++;
    if (bus.cpu_rvalid !== 1'b1 || bus.ld_rvalid !== 1'b0 || bus.rdata !== 16'h25) begin
      miscompares++;
      $display("FAIL rv_cpu: got cpu=%b ld=%b rdata=%h want 1 0 0025",
               bus.cpu_rvalid, bus.ld_rvalid, bus.rdata);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (bus.cpu_rvalid !== 1'b0 || bus.ld_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL rv_idle: got cpu=%b ld=%b want 0 0", bus.cpu_rvalid, bus.ld_rvalid);
    end
    tick();
  endtask

  task automatic test_reset_mid_lock();
    drive(0, 0, 0, 0, 1, 0, 1, 3, 0);
    @(negedge clk);
    vectors++;
    if (bus.ld_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL rml_gnt: got %b want 1", bus.ld_gnt);
    end
    tick();
    drive(1, 0, 0, 0, 1, 1, 1, 4, 16'h44);
    #1;
    vectors++;
    if (bus.ld_rvalid !== 1'b1 || bus.mem_we !== 1'b1 || bus.ld_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL rml_pre: got rv=%b we=%b gnt=%b want 1 1 1",
               bus.ld_rvalid, bus.mem_we, bus.ld_gnt);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.ld_rvalid !== 1'b0 || bus.ld_gnt !== 1'b0 || bus.cpu_gnt !== 1'b0
        || bus.mem_we !== 1'b0 || bus.cpu_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL rml_async: got rv=%b ld=%b cpu=%b we=%b stall=%b want 0 0 0 0 0",
               bus.ld_rvalid, bus.ld_gnt, bus.cpu_gnt, bus.mem_we, bus.cpu_stall);
    end
    tick();
    vectors++;
    if (bus.ld_rvalid !== 1'b0 || bus.cpu_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL rml_hold: got ld=%b cpu=%b want 0 0", bus.ld_rvalid, bus.cpu_rvalid);
    end
    rst_n = 1'b1;
    drive(1, 0, 4, 0, 0, 0, 0, 0, 0);
    #1;
    vectors++;
    if (bus.cpu_gnt !== 1'b1 || bus.cpu_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL rml_first: got gnt=%b stall=%b want 1 0", bus.cpu_gnt, bus.cpu_stall);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    vectors++;
    if (bus.cpu_rvalid !== 1'b1 || bus.rdata !== 16'hA004) begin
      miscompares++;
      $display("FAIL rml_nowrite: got rv=%b rdata=%h want 1 a004", bus.cpu_rvalid, bus.rdata);
    end
    tick();
  endtask

  task automatic test_idle();
    drive(0, 0, 16'h9, 16'h77, 0, 1, 0, 16'hA, 16'h88);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.cpu_gnt !== 1'b0 || bus.ld_gnt !== 1'b0 || bus.mem_we !== 1'b0
          || bus.cpu_rvalid !== 1'b0 || bus.ld_rvalid !== 1'b0) begin
        miscompares++;
        $display("FAIL idle[%0d]: got cg=%b lg=%b we=%b crv=%b lrv=%b want all 0", i,
                 bus.cpu_gnt, bus.ld_gnt, bus.mem_we, bus.cpu_rvalid, bus.ld_rvalid);
      end
      tick();
    end
    drive(1, 0, 0, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    vectors++;
    if (bus.cpu_gnt !== 1'b1 || bus.ld_gnt !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_wait0: got cpu=%b ld=%b want 1 0", bus.cpu_gnt, bus.ld_gnt);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0] ref_mem [256];
    bit           m_lock, m_crv, m_lrv;
    int           m_wait;
    logic [W-1:0] m_rd;
    bit           cr, cw, lr, lw, ll, e_cg, e_lg, e_we;
    logic [W-1:0] ca, cd, la, ld, e_a, e_wd;

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    m_lock = 0;
    m_crv  = 0;
    m_lrv  = 0;
    m_wait = 0;
    m_rd   = '0;
    rst_n  = 1'b1;

    for (int n = 0; n < 400; n++) begin
      cr = ($urandom_range(0, 9) < 7);
      cw = $urandom_range(0, 1) == 1;
      lr = ($urandom_range(0, 9) < 6);
      lw = $urandom_range(0, 1) == 1;
      ll = ($urandom_range(0, 9) < 4);
      ca = 16'($urandom_range(0, 15));
      la = 16'($urandom_range(0, 15));
      cd = 16'($urandom);
      ld = 16'($urandom);
      drive(cr, cw, ca, cd, lr, lw, ll, la, ld);

      e_cg = 0;
      e_lg = 0;
      if (m_lock) e_lg = lr;
      else if (lr && m_wait == MW) e_lg = 1;
      else if (cr) e_cg = 1;
      else if (lr) e_lg = 1;
      e_we = (e_cg && cw) || (e_lg && lw);
      e_a  = e_lg ? la : ca;
      e_wd = e_lg ? ld : cd;

      @(negedge clk);
      vectors++;
      if (bus.cpu_gnt !== e_cg || bus.ld_gnt !== e_lg) begin
        miscompares++;
        $display("FAIL rnd_gnt[%0d]: got cpu=%b ld=%b want %b %b",
                 n, bus.cpu_gnt, bus.ld_gnt, e_cg, e_lg);
      end
      vectors++;
      if (bus.cpu_stall !== (cr && !e_cg)) begin
        miscompares++;
        $display("FAIL rnd_stall[%0d]: got %b want %b", n, bus.cpu_stall, cr && !e_cg);
      end
      vectors++;
      if (bus.mem_we !== e_we || ((e_cg || e_lg) && bus.mem_a !== e_a)
          || (e_we && bus.mem_wd !== e_wd)) begin
        miscompares++;
        $display("FAIL rnd_bus[%0d]: got we=%b a=%h wd=%h want %b %h %h",
                 n, bus.mem_we, bus.mem_a, bus.mem_wd, e_we, e_a, e_wd);
      end
      vectors++;
      if (bus.cpu_rvalid !== m_crv || bus.ld_rvalid !== m_lrv
          || ((m_crv || m_lrv) && bus.rdata !== m_rd)) begin
        miscompares++;
        $display("FAIL rnd_rd[%0d]: got crv=%b lrv=%b rdata=%h want %b %b %h",
                 n, bus.cpu_rvalid, bus.ld_rvalid, bus.rdata, m_crv, m_lrv, m_rd);
      end
      vectors++;
      if (bus.cpu_rvalid === 1'b1 && bus.ld_rvalid === 1'b1) begin
        miscompares++;
        $display("FAIL rnd_both_rv[%0d]: got 1 1 want at most one", n);
      end

      @(posedge clk);
      m_crv = e_cg && !cw;
      m_lrv = e_lg && !lw;
      m_rd  = ref_mem[e_a[7:0]];
      if (e_we) ref_mem[e_a[7:0]] = e_wd;
      if (lr && !e_lg) m_wait = (m_wait + 1 > MW) ? MW : m_wait + 1;
      else m_wait = 0;
      if (m_lock) m_lock = lr && ll;
      else m_lock = e_lg && ll;
      #1;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  initial begin
    test_reset();
    test_cpu_rw();
    test_starvation();
    test_lock_burst();
    test_rvalid_seq();
    test_reset_mid_lock();
    test_idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
